mdu_div: RTL and testbench

- Iterative 32-bit integer divider for the MIPS datapath; executes DIV and DIVU and produces the LO (quotient) and HI (remainder) values.
- It is the multi-cycle counterpart to the single-cycle ALU: the ALU adds, subtracts and shifts combinationally, while this block runs restoring shift-subtract division over many cycles.
- It sits beside the ALU in the EX stage. The pipeline controller starts it with a pulse and stalls on busy.

---
 rtl/mdu_div_pkg.sv | 14 +
 rtl/mdu_div_step.sv | 27 ++
 rtl/mdu_div.sv | 130 +++++++++++++
 tb/tb_mdu_div.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_pkg.sv
// Shared constants for the iterative MIPS divider: FSM encoding, iteration count
// and the fixed divide-by-zero quotient.
package mdu_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DIV_CYCLES = 32;

    localparam logic [31:0] DIVZ_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring shift-subtract step on {rem, quo}; purely combinational.
// The shifted remainder can reach 33 bits when the divisor is >= 2^31.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic             unused_trial_bit;

    assign rem_sh           = {rem_i, quo_i[WIDTH-1]};
    assign trial            = {1'b0, rem_sh} - {2'b00, dvsr_i};
    assign fits             = ~trial[WIDTH+1];
    // A successful trial is always below the divisor, so its top bit is zero.
    assign unused_trial_bit = trial[WIDTH];

    assign rem_o = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_div.sv
// Iterative DIV/DIVU unit: start accepted in IDLE/DONE, busy for 32 CALC + 1 FIX cycles,
// done pulses in the 34th cycle; divide-by-zero finishes in one cycle. start while busy is dropped.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sig,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    logic [1:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             accept;

    // 0x80000000 negates to itself and is then used as an unsigned magnitude.
    assign mag_a  = (sig && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign mag_b  = (sig && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (B == '0) begin
                        q_d     = DIVZ_Q;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dvsr_d  = mag_b;
                        quo_d   = mag_a;
                        rem_d   = '0;
                        cnt_d   = '0;
                        negq_d  = sig && (A[WIDTH-1] != B[WIDTH-1]);
                        negr_d  = sig && A[WIDTH-1];
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                q_d     = negq_q ? (~quo_q + 1'b1) : quo_q;
                r_d     = negr_q ? (~rem_q + 1'b1) : rem_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mdu_div.sv
// Scoreboard bench for mdu_div: directed corner cases plus randomized DIV/DIVU
// checked against a plain-arithmetic reference model.
module tb_mdu_div;

    logic        clk = 1'b0;
    logic        reset, start, sig;
    logic [31:0] A, B, Q, R;
    logic        busy, done, div_zero;

    always #5 clk = ~clk;

    mdu_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sig      (sig),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sd;
        e.dz = (b == 0);
        if (b == 0) begin
            e.q = 32'hFFFFFFFF;
            e.r = a;
        end else if (s) begin
            sa  = longint'($signed(a));
            sd  = longint'($signed(b));
            e.q = 32'(sa / sd);
            e.r = 32'(sa % sd);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: done=1 with no operation pending, expected done=0");
            end else begin
                e = sb_q.pop_front();
                check("Q", Q, e.q);
                check("R", R, e.r);
                check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
            end
        end
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        sig   = s;
        A     = a;
        B     = b;
        start = 1'b1;
        sb_q.push_back(model(s, a, b));
    endtask

    // Counts cycles after the accepting edge until done; optionally re-pulses start at cycle inj.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int inj);
        int k    = 0;
        int nb   = 0;
        bit seen = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
            end else if (k == inj) begin
                start = 1'b1;
                A     = 32'd9;
                B     = 32'd3;
            end else begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          s;
        reset = 1'b1;
        start = 1'b0;
        sig   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_Q", Q, 32'd0);
        check("rst_R", R, 32'd0);
        check("rst_div_zero", {31'b0, div_zero}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 32'd100, 32'd7);                   wait_done("udiv", 34, 33, 0);
        @(negedge clk);
        issue(1'b1, 32'hFFFFFFF9, 32'd2);              wait_done("sdiv_neg_a", 34, 33, 0);
        @(negedge clk);
        issue(1'b1, 32'd7, 32'hFFFFFFFE);              wait_done("sdiv_neg_b", 34, 33, 0);
        @(negedge clk);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);       wait_done("s_overflow", 34, 33, 0);
        @(negedge clk);
        issue(1'b0, 32'h80000000, 32'hFFFFFFFF);       wait_done("u_contrast", 34, 33, 0);
        @(negedge clk);
        issue(1'b0, 32'd1234, 32'd0);                  wait_done("divz", 1, 0, 0);
        @(negedge clk);
        issue(1'b0, 32'd50, 32'd5);                    wait_done("start_ignored", 34, 33, 10);
        issue(1'b0, 32'd9, 32'd3);                     wait_done("back_to_back", 34, 33, 0);

        // Reset in the middle of a division: expectation is dropped, no done may follow.
        repeat (2) @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_Q", Q, 32'd0);
        check("abort_R", R, 32'd0);
        check("abort_div_zero", {31'b0, div_zero}, 32'd0);
        repeat (40) @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3);                  wait_done("after_abort", 34, 33, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = $urandom;
                default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h80000000;
            issue(s, a, b);
            wait_done("random", (b == 0) ? 1 : 34, (b == 0) ? 0 : 33, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
